// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo
//   Serializes up to two in-order retirements per cycle into a single-issue
//   trace stream for a downstream log counter. The FIFO holds DEPTH 32-bit
//   entries. When there is not enough room, the younger entries are dropped
//   and counted.
//
// Ports
//   clk            single clock, rising edge
//   resetn         synchronous reset, active HIGH despite the name
//   commit0_*      slot 0 (older) retirement: valid + instruction word
//   commit1_*      slot 1 (younger) retirement: valid + instruction word
//   inst_out       registered head entry, 32'h0 when idle
//   inst_out_valid inst_out carries a real retired instruction
//   fifo_count     current occupancy, 0..DEPTH
//   overflow_cnt   saturating count of dropped instructions
//   overflow       sticky flag, set on the first drop

module commit_trace_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     commit0_valid,
  input  logic [31:0]              commit0_inst,
  input  logic                     commit1_valid,
  input  logic [31:0]              commit1_inst,
  output logic [31:0]              inst_out,
  output logic                     inst_out_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [31:0]              overflow_cnt,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   inst_q, inst_d;
  logic          valid_q, valid_d;
  logic [31:0]   ovf_cnt_q, ovf_cnt_d;
  logic          ovf_q, ovf_d;

  logic          pop;
  logic [CW:0]   free;
  logic [1:0]    n_req;
  logic [1:0]    acc;
  logic [1:0]    drop;
  logic [31:0]   wr_data0;
  logic [32:0]   ovf_sum;

  always_comb begin
    pop   = (count_q != '0);
    // A pop in the same cycle frees a slot for this cycle's pushes.
    free  = (CW + 1)'(DEPTH) - {1'b0, count_q} + {{CW{1'b0}}, pop};
    n_req = {1'b0, commit0_valid} + {1'b0, commit1_valid};

    if ({{(CW - 1){1'b0}}, n_req} <= free) begin
      acc = n_req;
    end else if (free == (CW + 1)'(1)) begin
      acc = 2'd1;  // only the older of the two fits
    end else begin
      acc = 2'd0;
    end
    drop = n_req - acc;

    // The first accepted entry is slot 0 if present, otherwise slot 1 alone.
    wr_data0 = commit0_valid ? commit0_inst : commit1_inst;

    rd_ptr_d = rd_ptr_q + AW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(acc);
    count_d  = count_q - CW'(pop) + CW'(acc);

    inst_d  = pop ? mem_q[rd_ptr_q] : 32'h0;
    valid_d = pop;

    ovf_sum   = {1'b0, ovf_cnt_q} + 33'(drop);
    ovf_cnt_d = ovf_sum[32] ? 32'hFFFF_FFFF : ovf_sum[31:0];
    ovf_d     = ovf_q | (drop != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      inst_q    <= 32'h0;
      valid_q   <= 1'b0;
      ovf_cnt_q <= 32'h0;
      ovf_q     <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      inst_q    <= inst_d;
      valid_q   <= valid_d;
      ovf_cnt_q <= ovf_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage is not reset; writes are suppressed during reset so that commits
  // presented while resetn is high are discarded.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      if (acc != 2'd0) begin
        mem_q[wr_ptr_q] <= wr_data0;
      end
      if (acc == 2'd2) begin
        mem_q[wr_ptr_q + AW'(1)] <= commit1_inst;
      end
    end
  end

  assign inst_out       = inst_q;
  assign inst_out_valid = valid_q;
  assign fifo_count     = count_q;
  assign overflow_cnt   = ovf_cnt_q;
  assign overflow       = ovf_q;

endmodule

// File: doc/commit_trace_fifo.md
COMMIT_TRACE_FIFO -- requirements
Module: commit_trace_fifo

Interface
REQ-001 The block SHALL be parameterised by DEPTH, default 8, giving the number of 32-bit trace entries stored; legal values are powers of two from 4 to 64.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 resetn  input  1  synchronous, active-high reset; the block resets on any rising edge of clk where resetn = 1.
REQ-004 commit0_valid  input  1  slot 0 (older) instruction retired this cycle.
REQ-005 commit0_inst  input  32  slot 0 retired instruction word.
REQ-006 commit1_valid  input  1  slot 1 (younger) instruction retired this cycle.
REQ-007 commit1_inst  input  32  slot 1 retired instruction word.
REQ-008 inst_out  output  32  serialized instruction word fed to the downstream log counter; 32'h0 when idle.
REQ-009 inst_out_valid  output  1  inst_out carries a real retired instruction this cycle.
REQ-010 fifo_count  output  log2(DEPTH)+1  current occupancy.
REQ-011 overflow_cnt  output  32  number of retired instructions dropped, saturating.
REQ-012 overflow  output  1  sticky flag, set on the first drop.

Function
REQ-013 The block SHALL convert 0-2 retirements per cycle into at most one instruction per cycle on inst_out, preserving program order.
REQ-014 Program order SHALL be: slot 0 before slot 1 within a cycle; earlier cycles before later cycles.
REQ-015 commit1_valid=1 with commit0_valid=0 SHALL be treated as a single push of commit1_inst, with no gap entry.
REQ-016 Pop: at each edge where fifo_count>0 before the edge, the head entry SHALL be loaded into inst_out with inst_out_valid=1, and the head SHALL advance.
REQ-017 At each edge where fifo_count=0 before the edge, inst_out SHALL be loaded with 32'h0 and inst_out_valid with 0.
REQ-018 There SHALL be no bypass: an entry pushed at edge N appears on inst_out no earlier than after edge N+1, so the minimum latency is 2 edges.
REQ-019 Free space SHALL be computed as DEPTH - fifo_count + pop, where pop=1 if fifo_count>0, so a simultaneous pop frees a slot in the same cycle.
REQ-020 If free space is at least the number of valid pushes, all pushes SHALL be accepted.
REQ-021 If free space=1 and two pushes are requested, the older (slot 0) SHALL be accepted and the slot 1 entry SHALL be dropped.
REQ-022 If free space=0, all requested pushes SHALL be dropped.
REQ-023 fifo_count(next) SHALL equal fifo_count - pop + accepted; it SHALL never exceed DEPTH or go below 0.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH with no lost or duplicated entry at the wrap point.
REQ-025 overflow_cnt SHALL increase by the number dropped in the cycle (0, 1 or 2), saturating at 32'hFFFFFFFF without wrapping.
REQ-026 overflow SHALL be set to 1 on the first dropped instruction and SHALL hold until reset.
REQ-027 Entries SHALL be stored verbatim; the block SHALL NOT decode or filter instruction words.

Reset
REQ-028 When resetn=1 at an edge, the block SHALL set: inst_out=32'h0, inst_out_valid=0, fifo_count=0, overflow_cnt=0, overflow=0, both pointers=0.
REQ-029 Reset SHALL take priority over push and pop in the same cycle; commits presented during reset SHALL be discarded.
REQ-030 A reset during activity SHALL discard all buffered entries; the first output after reset SHALL be a commit presented after reset deasserts.
REQ-031 Storage array contents need not be reset.

Verification
REQ-032 Single push: after reset, commit0 A=32'h1111_0001 for one cycle -> inst_out=A with valid=1 exactly 2 edges later, then 32'h0/valid=0.
REQ-033 Dual push order: commit0=A and commit1=B in one cycle -> inst_out A then B on consecutive cycles; fifo_count sequence 2,1,0.
REQ-034 Slot 1 only: commit1_valid=1 with commit1_inst=C and commit0_valid=0 -> C output once, with no 32'h0 gap entry and fifo_count peak of 1.
REQ-035 Overflow (DEPTH=8): dual pushes every cycle for 10 cycles (20 instructions) -> fifo_count saturates at 8, overflow=1, and overflow_cnt equals 20 minus the number accepted; the accepted stream is an in-order prefix per cycle, and slot 1 is dropped first whenever free space=1.
REQ-036 Wrap and reset: stream 3*DEPTH sequential words at one per cycle -> output equals input in order; then assert resetn mid-stream -> all outputs return to reset values on the next edge, and no pre-reset word appears afterwards.
